// File: rtl/window_acc_ctrl_pkg.sv
// uBrain_acc_pkg: shared defaults, FSM states and width helper for the window accumulator feeder
package uBrain_acc_pkg;
   localparam int NBIT_D   = 64;
   localparam int IWID_D   = 7;
   localparam int OWID_D   = 17;
   localparam int WINLEN_D = 1024;
   typedef enum logic [1:0] {IDLE, CLR_FIRST, ACC, SWAP} state_t;
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/window_acc_ctrl_popcount_tree.sv
// popcount_tree: combinational NBIT-to-IWID adder tree, laid out as a heap over a power-of-two leaf row
module popcount_tree
   import uBrain_acc_pkg::*;
#(
   parameter int NBIT = NBIT_D,
   parameter int IWID = IWID_D
) (
   input  logic [NBIT-1:0] iBits,
   output logic [IWID-1:0] oCount
);
   localparam int P = 1 << $clog2(NBIT);
   logic [IWID-1:0] t [2*P-1];
   genvar i;
   for (i = 0; i < P; i++) begin : g_leaf
      if (i < NBIT) begin : g_bit
         assign t[P-1+i] = IWID'(iBits[i]);
      end else begin : g_pad
         assign t[P-1+i] = '0;
      end
   end
   for (i = 0; i < P-1; i++) begin : g_node
      assign t[i] = t[2*i+1] + t[2*i+2];
   end
   assign oCount = t[0];
endmodule

// File: rtl/window_acc_ctrl.sv
// window_acc_ctrl: feeds popcounts of unary slices into a ping-pong accumulator and sequences its controls per window
module window_acc_ctrl
   import uBrain_acc_pkg::*;
#(
   parameter int NBIT   = NBIT_D,
   parameter int IWID   = IWID_D,
   parameter int OWID   = OWID_D,
   parameter int WINLEN = WINLEN_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iEnable,
   input  logic            iValid,
   output logic            oReady,
   input  logic [NBIT-1:0] iBits,
   output logic [IWID-1:0] oData,
   output logic            oAccSel,
   output logic            oClear,
   output logic            oHold,
   output logic            oDone
);
   localparam int CW = cnt_w(WINLEN);
   if (WINLEN < 1 || (2**IWID) <= NBIT || (2**OWID) <= NBIT*WINLEN) begin : g_param_check
      $error("window_acc_ctrl: parameter widths cannot hold the counts");
   end
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IWID-1:0] pc;
   logic            last;
   popcount_tree #(.NBIT(NBIT), .IWID(IWID)) u_pc (.iBits(iBits), .oCount(pc));
   assign oReady = state == ACC;
   assign last   = cnt == CW'(WINLEN - 1);
   // FSM plus registered accumulator controls; the swap edge coincides with the accumulator adding the last beat
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         oData   <= '0;
         oAccSel <= 1'b0;
         oClear  <= 1'b0;
         oHold   <= 1'b1;
         oDone   <= 1'b0;
      end else begin
         oData  <= '0;
         oClear <= 1'b0;
         oHold  <= 1'b1;
         oDone  <= 1'b0;
         case (state)
            IDLE: if (iEnable) begin
               state  <= CLR_FIRST;
               oClear <= 1'b1;
               oHold  <= 1'b0;
            end
            CLR_FIRST: state <= ACC;
            ACC: if (iValid) begin
               oData <= pc;
               oHold <= 1'b0;
               cnt   <= last ? '0 : cnt + 1'b1;
               if (last) state <= SWAP;
            end
            SWAP: begin
               oAccSel <= ~oAccSel;
               oClear  <= 1'b1;
               oHold   <= 1'b0;
               oDone   <= 1'b1;
               state   <= iEnable ? ACC : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_window_acc_ctrl.sv
// tb_window_acc_ctrl: scoreboard bench with a ping-pong accumulator model for WINLEN=4 and WINLEN=1 instances
module tb_window_acc_ctrl;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, vld = 1'b1;
   logic [63:0] bits = '1, bits1 = 64'd1;
   logic rdy, sel, clr, hold, done, rdy1, sel1, clr1, hold1, done1;
   logic [6:0] data, data1;
   int total = 0, bad = 0;
   int cyc = 0, last1 = -1, done1_cnt = 0, done_cnt = 0, pushed = 0;
   int wsum = 0, wcnt = 0, pop_prev = 0;
   bit acc_prev = 0, esel = 0, esel1 = 0;
   int exp_q [$];
   logic [16:0] ar [2], ar1 [2];
   logic [16:0] accout, acc1out;

   always #5 clk = ~clk;

   window_acc_ctrl #(.NBIT(64), .IWID(7), .OWID(17), .WINLEN(4)) u0 (
      .clk(clk), .rst(rst), .iEnable(en), .iValid(vld), .oReady(rdy), .iBits(bits),
      .oData(data), .oAccSel(sel), .oClear(clr), .oHold(hold), .oDone(done));
   window_acc_ctrl #(.NBIT(64), .IWID(7), .OWID(17), .WINLEN(1)) u1 (
      .clk(clk), .rst(rst), .iEnable(1'b1), .iValid(1'b1), .oReady(rdy1), .iBits(bits1),
      .oData(data1), .oAccSel(sel1), .oClear(clr1), .oHold(hold1), .oDone(done1));

   task automatic chk(input string name, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [63:0] mk(input int p);
      logic [63:0] b = '0;
      while ($countones(b) < p) b[$urandom_range(63, 0)] = 1'b1;
      return b;
   endfunction

   // accumulator models: clear zeroes the selected register, otherwise it adds unless held; output is the other register
   always @(posedge clk or posedge rst)
      if (rst) begin
         ar[0] <= '0; ar[1] <= '0; ar1[0] <= '0; ar1[1] <= '0;
      end else begin
         if (clr) ar[sel] <= '0;
         else if (!hold) ar[sel] <= ar[sel] + 17'(data);
         if (clr1) ar1[sel1] <= '0;
         else if (!hold1) ar1[sel1] <= ar1[sel1] + 17'(data1);
      end
   assign accout  = sel ? ar[0] : ar[1];
   assign acc1out = sel1 ? ar1[0] : ar1[1];

   // scoreboard: every fourth accepted beat closes a window and queues its expected sum
   always @(posedge clk or posedge rst)
      if (rst) begin
         wsum <= 0; wcnt <= 0; acc_prev <= 0; pop_prev <= 0;
         pushed <= pushed - exp_q.size();
         exp_q.delete();
      end else begin
         acc_prev <= vld && rdy;
         pop_prev <= $countones(bits);
         if (vld && rdy) begin
            if (wcnt == 3) begin
               exp_q.push_back(wsum + $countones(bits));
               pushed <= pushed + 1;
               wsum <= 0; wcnt <= 0;
            end else begin
               wsum <= wsum + $countones(bits);
               wcnt <= wcnt + 1;
            end
         end
      end

   // monitor for the WINLEN=4 instance
   always @(negedge clk)
      if (rst) esel <= 0;
      else begin
         if (acc_prev) begin
            chk("beat_data", data, pop_prev);
            chk("beat_hold", hold, 0);
            chk("beat_clr", clr, 0);
         end else begin
            chk("idle_data", data, 0);
            if (!clr) chk("gap_hold", hold, 1);
         end
         if (clr) chk("clr_hold", hold, 0);
         if (done) begin
            chk("done_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("win_sum", accout, exp_q.pop_front());
            chk("acc_sel", sel, !esel);
            esel <= !esel;
            done_cnt <= done_cnt + 1;
         end
      end

   // monitor for the WINLEN=1 instance
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         last1 <= -1; esel1 <= 0;
      end else if (done1) begin
         chk("w1_sum", acc1out, 1);
         chk("w1_sel", sel1, !esel1);
         chk("w1_ready", rdy1, 1);
         if (last1 >= 0) chk("w1_period", cyc - last1, 2);
         esel1 <= !esel1;
         last1 <= cyc;
         done1_cnt <= done1_cnt + 1;
      end
   end

   initial forever begin
      @(negedge clk);
      bits1 = 64'd1 << $urandom_range(63, 0);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [63:0] b, input int gap);
      bit ok = 0;
      vld = 1'b1; bits = b;
      for (int c = 0; c < 50 && !ok; c++)
         if (rdy) ok = 1; else @(negedge clk);
      chk("send_ready", ok, 1);
      if (ok) @(posedge clk);
      @(negedge clk);
      vld = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic chk_reset();
      chk("rst_ready", rdy, 0);
      chk("rst_data", data, 0);
      chk("rst_sel", sel, 0);
      chk("rst_clr", clr, 0);
      chk("rst_hold", hold, 1);
      chk("rst_done", done, 0);
   endtask

   initial begin
      int n = 0;
      repeat (2) @(negedge clk);
      chk_reset();
      rst = 1'b0;
      while (n < 20 && !done) begin
         @(negedge clk);
         n++;
      end
      chk("first_done_latency", n, 7);
      chk("first_done_sel", sel, 1);
      vld = 1'b0;
      for (int p = 1; p <= 4; p++) send(mk(p), 1);
      repeat (4) send('1, 0);
      repeat (4) send('0, 0);
      repeat (2) send(mk($urandom_range(64, 0)), 0);
      en = 1'b0;
      repeat (2) send(mk($urandom_range(64, 0)), 0);
      repeat (4) @(negedge clk);
      chk("idle_ready", rdy, 0);
      chk("idle_hold", hold, 1);
      en = 1'b1;
      repeat (2) send(mk($urandom_range(64, 0)), 0);
      #2 rst = 1'b1;
      #1 chk_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) send(mk($urandom_range(64, 0)), $urandom_range(2, 0));
      repeat (16) send({$urandom, $urandom}, $urandom_range(2, 0));
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      chk("done_count", done_cnt, pushed);
      chk("w1_activity", done1_cnt > 10, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/window_acc_ctrl.md
Name: window_acc_ctrl

Overview:
- Upstream feeder and sequencer for the 7-in/17-out double-buffered accumulator in the uBrain datapath.
- Accepts NBIT-wide unary bit slices under a valid/ready handshake and popcounts each slice into a registered IWID-bit count.
- Drives the accumulator's accumulate-select, clear and hold controls so each window of WINLEN accepted slices lands in one ping-pong register.
- Pulses oDone when a completed window sum is visible on the accumulator output.

Parameters:
- NBIT, 64, width of the unary bit slice per beat.
- IWID, 7, popcount width; must satisfy 2^IWID > NBIT.
- OWID, 17, accumulator width; must satisfy 2^OWID > NBIT*WINLEN (checked by elaboration assertion).
- WINLEN, 1024, accepted beats per window; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- iEnable  in  1  level; start or continue windows
- iValid  in  1  slice valid
- oReady  out  1  slice accepted when iValid & oReady
- iBits  in  NBIT  unary bit slice
- oData  out  IWID  registered popcount, to accumulator data input
- oAccSel  out  1  to accumulator select (0 = reg0 accumulates)
- oClear  out  1  to accumulator clear
- oHold  out  1  to accumulator hold
- oDone  out  1  one-cycle pulse: finished window sum valid on accumulator output

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous and active-high on rst. The accumulator is reset from the same source (inverted for its active-low input).
- Reset values: state IDLE, oData=0, oAccSel=0, oClear=0, oHold=1, oDone=0, beat counter=0.
- Output timing: all outputs except oReady are registered. oReady is combinational and equals (state==ACC).
- IDLE state: oHold=1, oClear=0. If iEnable=1, go to CLR_FIRST.
- CLR_FIRST state (1 cycle):
  - Registered outputs on entry: oClear=1, oHold=0, oData=0.
  - oAccSel unchanged, oDone=0.
  - Next state ACC.
- ACC state:
  - On each accepted beat, next edge: oData=popcount(iBits), oHold=0, oClear=0, counter+1.
  - With no acceptance: oData=0, oHold=1.
- Last beat of window (acceptance with counter==WINLEN-1):
  - Counter returns to 0; next state SWAP.
- SWAP state (1 cycle):
  - Registered outputs on entry: oAccSel toggled, oClear=1, oHold=0, oData=0, oDone=1.
  - oReady=0 in this cycle.
  - Next state ACC if iEnable=1, else IDLE.
- Window-end timing:
  - Last beat accepted at edge k. Accumulator adds it at edge k+1, while oAccSel toggles and oDone pulses at edge k+1.
  - The accumulator output therefore shows the complete sum from k+1 until the next oDone.
  - The other register is cleared at edge k+2.
- Throughput: a window needs WINLEN+1 cycles under continuous iValid.
- iEnable deasserted mid-window: the window completes normally, then SWAP, then IDLE.
- iValid low in ACC: no count change; oHold=1 next cycle.
- Reset mid-window: partial sum is discarded, no oDone, and the next window restarts with oAccSel=0.
- Width rules:
  - Popcount is zero-extended to IWID.
  - Counter width is clog2(WINLEN) with a minimum of 1.
  - WINLEN=1 gives alternating ACC/SWAP.
- Prohibited output combinations: oClear=1 never coincides with oHold=1 or with a nonzero oData.

Decomposition:
- Shared package uBrain_acc_pkg:
  - NBIT, IWID, OWID, WINLEN defaults.
  - state enum {IDLE, CLR_FIRST, ACC, SWAP}.
  - clog2 helper constant.
- One sub-module, popcount_tree: parameterised NBIT-to-IWID combinational adder tree. Its output is registered in this block.

Test Plan:
- Reset with iEnable=1, WINLEN=4, iBits all ones, iValid constant:
  - oDone rises 6 cycles after the CLR_FIRST edge.
  - The accumulator paired under the same clk/rst shows 256 from reg0 while oAccSel=1.
- Window with iBits popcounts 1,2,3,4 and iValid gaps every other cycle:
  - oHold=1 in the gap cycles.
  - Window sum is 10; oDone fires exactly once.
- Two back-to-back windows with popcounts 64×4, then 0×4:
  - oAccSel goes 0→1→0.
  - Sums read at each oDone are 256, then 0, proving the clear of the reused register.
- iEnable dropped after beat 2 of 4:
  - Beats 3–4 are still accepted and oDone pulses.
  - FSM then goes to IDLE with oReady=0 and oHold=1.
- rst asserted between beats 2 and 3:
  - All outputs return to reset values in the same cycle, asynchronously.
  - After release, the first oDone sum excludes pre-reset beats.
- WINLEN=1 with single bits set (popcount 1):
  - oDone every 2 cycles.
  - Sums are 1 each.
  - oAccSel toggles every oDone.
